// File: rtl/tt_um_jimktrains_vslc_pkg.sv
// rtl/tt_um_jimktrains_vslc_pkg.sv - shared encodings for the vslc timer scheduler
package tt_um_jimktrains_vslc_pkg;

    localparam logic [1:0] FIELD_PA    = 2'd0;
    localparam logic [1:0] FIELD_PB    = 2'd1;
    localparam logic [1:0] FIELD_CTRL  = 2'd2;
    localparam logic [1:0] FIELD_PRESC = 2'd3;

    localparam int CTRL_EN      = 0;
    localparam int CTRL_ONESHOT = 1;

    typedef enum logic {
        S_IDLE,
        S_HOLD
    } state_t;

endpackage

// File: rtl/tt_um_jimktrains_vslc_prescaler.sv
// rtl/tt_um_jimktrains_vslc_prescaler.sv - divide clk into the shared timer_clk
module tt_um_jimktrains_vslc_prescaler
    import tt_um_jimktrains_vslc_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] divisor,
    input  logic       restart,
    output logic       timer_clk
);

    logic [7:0] count;

    // restart realigns the phase so a new divisor starts from a clean low half-period
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            count     <= 8'd0;
            timer_clk <= 1'b0;
        end else if (restart) begin
            count     <= 8'd0;
            timer_clk <= 1'b0;
        end else if (count == divisor) begin
            count     <= 8'd0;
            timer_clk <= ~timer_clk;
        end else begin
            count <= count + 8'd1;
        end
    end

endmodule

// File: rtl/tt_um_jimktrains_vslc_timer_sched.sv
// rtl/tt_um_jimktrains_vslc_timer_sched.sv - config, commit sequencing and one-shot control for vslc timers
module tt_um_jimktrains_vslc_timer_sched
    import tt_um_jimktrains_vslc_pkg::*;
#(
    parameter int         NUM_CH       = 4,
    parameter int         HOLD_CYCLES  = 2,
    parameter logic [7:0] PRESCALE_RST = 8'd0
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  cfg_valid,
    output logic                  cfg_ready,
    input  logic [1:0]            cfg_ch,
    input  logic [1:0]            cfg_field,
    input  logic [7:0]            cfg_data,
    input  logic [NUM_CH-1:0]     timer_out_in,
    output logic                  timer_clk,
    output logic [8*NUM_CH-1:0]   period_a,
    output logic [8*NUM_CH-1:0]   period_b,
    output logic [NUM_CH-1:0]     timer_enabled,
    output logic [NUM_CH-1:0]     done
);

    localparam int HW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;

    state_t            state_q;
    state_t            state_d;
    logic [HW-1:0]     hold_cnt;
    logic [1:0]        hold_ch;
    logic              pending_en;
    logic [7:0]        divisor;
    logic [7:0]        shadow_a [NUM_CH];
    logic [7:0]        shadow_b [NUM_CH];
    logic [NUM_CH-1:0] oneshot;
    logic [NUM_CH-1:0] timer_out_q;
    logic [NUM_CH-1:0] fall;

    logic wr;
    logic ch_ok;
    logic commit;
    logic presc_wr;
    logic hold_done;

    assign cfg_ready = (state_q == S_IDLE);
    assign wr        = cfg_valid && cfg_ready;
    assign ch_ok     = (int'(cfg_ch) < NUM_CH);
    assign commit    = wr && (cfg_field == FIELD_CTRL) && ch_ok;
    assign presc_wr  = wr && (cfg_field == FIELD_PRESC);
    assign hold_done = (state_q == S_HOLD) && (hold_cnt == '0);
    assign fall      = timer_out_q & ~timer_out_in;

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: if (commit) state_d = S_HOLD;
            S_HOLD: if (hold_cnt == '0) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) state_q <= S_IDLE;
        else        state_q <= state_d;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            hold_cnt    <= '0;
            hold_ch     <= 2'd0;
            pending_en  <= 1'b0;
            divisor     <= PRESCALE_RST;
            oneshot     <= '0;
            timer_out_q <= '0;
            period_a    <= '0;
            period_b    <= '0;
            timer_enabled <= '0;
            done        <= '0;
            for (int i = 0; i < NUM_CH; i++) begin
                shadow_a[i] <= 8'd0;
                shadow_b[i] <= 8'd0;
            end
        end else begin
            timer_out_q <= timer_out_in;

            if (commit) begin
                hold_ch    <= cfg_ch;
                pending_en <= cfg_data[CTRL_EN];
                hold_cnt   <= HW'(HOLD_CYCLES - 1);
            end else if ((state_q == S_HOLD) && (hold_cnt != '0)) begin
                hold_cnt <= hold_cnt - 1'b1;
            end

            if (presc_wr) divisor <= cfg_data;

            // later assignments override earlier ones: a commit beats a same-edge one-shot fall
            for (int i = 0; i < NUM_CH; i++) begin
                if (fall[i] && timer_enabled[i] && oneshot[i]) begin
                    timer_enabled[i] <= 1'b0;
                    done[i]          <= 1'b1;
                end
                if (hold_done && (hold_ch == 2'(i))) begin
                    timer_enabled[i] <= pending_en;
                end
                if (wr && (cfg_ch == 2'(i))) begin
                    case (cfg_field)
                        FIELD_PA: shadow_a[i] <= cfg_data;
                        FIELD_PB: shadow_b[i] <= cfg_data;
                        FIELD_CTRL: begin
                            period_a[8*i +: 8] <= shadow_a[i];
                            period_b[8*i +: 8] <= shadow_b[i];
                            oneshot[i]         <= cfg_data[CTRL_ONESHOT];
                            done[i]            <= 1'b0;
                            timer_enabled[i]   <= 1'b0;
                        end
                        default: ;
                    endcase
                end
            end
        end
    end

    tt_um_jimktrains_vslc_prescaler u_prescaler (
        .clk       (clk),
        .rst_n     (rst_n),
        .divisor   (divisor),
        .restart   (presc_wr),
        .timer_clk (timer_clk)
    );

endmodule

// File: tb/tb_tt_um_jimktrains_vslc_timer_sched.sv
// tb/tb_tt_um_jimktrains_vslc_timer_sched.sv - directed self-checking bench for the vslc timer scheduler
module tb_tt_um_jimktrains_vslc_timer_sched;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        cfg_valid;
    logic        cfg_ready;
    logic [1:0]  cfg_ch;
    logic [1:0]  cfg_field;
    logic [7:0]  cfg_data;
    logic [3:0]  timer_out_in;
    logic        timer_clk;
    logic [31:0] period_a;
    logic [31:0] period_b;
    logic [3:0]  timer_enabled;
    logic [3:0]  done;

    logic        cfg_valid2;
    logic        cfg_ready2;
    logic [1:0]  cfg_ch2;
    logic [1:0]  cfg_field2;
    logic [7:0]  cfg_data2;
    logic [1:0]  timer_out_in2;
    logic        timer_clk2;
    logic [15:0] period_a2;
    logic [15:0] period_b2;
    logic [1:0]  timer_enabled2;
    logic [1:0]  done2;

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    tt_um_jimktrains_vslc_timer_sched #(.NUM_CH(4), .HOLD_CYCLES(2), .PRESCALE_RST(8'd0)) dut (
        .clk(clk), .rst_n(rst_n), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
        .cfg_ch(cfg_ch), .cfg_field(cfg_field), .cfg_data(cfg_data),
        .timer_out_in(timer_out_in), .timer_clk(timer_clk), .period_a(period_a),
        .period_b(period_b), .timer_enabled(timer_enabled), .done(done)
    );

    tt_um_jimktrains_vslc_timer_sched #(.NUM_CH(2), .HOLD_CYCLES(2), .PRESCALE_RST(8'd0)) dut2 (
        .clk(clk), .rst_n(rst_n), .cfg_valid(cfg_valid2), .cfg_ready(cfg_ready2),
        .cfg_ch(cfg_ch2), .cfg_field(cfg_field2), .cfg_data(cfg_data2),
        .timer_out_in(timer_out_in2), .timer_clk(timer_clk2), .period_a(period_a2),
        .period_b(period_b2), .timer_enabled(timer_enabled2), .done(done2)
    );

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic drive(input logic v, input logic [1:0] ch, input logic [1:0] f, input logic [7:0] d);
        cfg_valid = v; cfg_ch = ch; cfg_field = f; cfg_data = d;
    endtask

    task automatic drive2(input logic v, input logic [1:0] ch, input logic [1:0] f, input logic [7:0] d);
        cfg_valid2 = v; cfg_ch2 = ch; cfg_field2 = f; cfg_data2 = d;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        drive(1'b1, 2'd1, 2'd2, 8'h01);
        drive2(1'b0, 2'd0, 2'd0, 8'h00);
        timer_out_in = 4'h0;
        timer_out_in2 = 2'h0;
        repeat (3) tick();
        vectors++;
        if ({period_a, period_b, timer_enabled, done, timer_clk} !== 73'd0) begin
            miscompares++;
            $display("FAIL reset_outputs got pa=%h pb=%h en=%b done=%b tclk=%b exp all 0",
                     period_a, period_b, timer_enabled, done, timer_clk);
        end
        rst_n = 1'b1;
        drive(1'b0, 2'd0, 2'd0, 8'h00);
        vectors++;
        if (cfg_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL reset_ready got %b exp 1", cfg_ready);
        end
        for (int k = 0; k < 4; k++) begin
            tick();
            vectors++;
            if (timer_clk !== ((k % 2) == 0)) begin
                miscompares++;
                $display("FAIL reset_tclk_toggle[%0d] got %b exp %b", k, timer_clk, (k % 2) == 0);
            end
        end
    endtask

    task automatic test_commit();
        drive(1'b1, 2'd1, 2'd0, 8'h05);
        tick();
        drive(1'b1, 2'd1, 2'd1, 8'h03);
        tick();
        vectors++;
        if (period_a[15:8] !== 8'h00 || period_b[15:8] !== 8'h00) begin
            miscompares++;
            $display("FAIL commit_shadow_only got pa=%h pb=%h exp 00 00", period_a[15:8], period_b[15:8]);
        end
        drive(1'b1, 2'd1, 2'd2, 8'h01);
        tick();
        drive(1'b0, 2'd0, 2'd0, 8'h00);
        for (int k = 0; k < 2; k++) begin
            vectors++;
            if (cfg_ready !== 1'b0 || timer_enabled[1] !== 1'b0) begin
                miscompares++;
                $display("FAIL commit_hold[%0d] got ready=%b en1=%b exp 0 0", k, cfg_ready, timer_enabled[1]);
            end
            tick();
        end
        vectors++;
        if (cfg_ready !== 1'b1 || timer_enabled !== 4'b0010 || period_a !== 32'h0000_0500 ||
            period_b !== 32'h0000_0300) begin
            miscompares++;
            $display("FAIL commit_done got ready=%b en=%b pa=%h pb=%h exp 1 0010 00000500 00000300",
                     cfg_ready, timer_enabled, period_a, period_b);
        end
    endtask

    task automatic test_prescaler();
        drive(1'b1, 2'd2, 2'd3, 8'h02);
        tick();
        drive(1'b0, 2'd0, 2'd0, 8'h00);
        for (int k = 0; k < 8; k++) begin
            vectors++;
            if (timer_clk !== (((k / 3) % 2) == 1)) begin
                miscompares++;
                $display("FAIL presc_seq[%0d] got %b exp %b", k, timer_clk, ((k / 3) % 2) == 1);
            end
            if (k < 7) tick();
        end
        drive(1'b1, 2'd0, 2'd3, 8'h02);
        tick();
        drive(1'b0, 2'd0, 2'd0, 8'h00);
        for (int k = 0; k < 5; k++) begin
            vectors++;
            if (timer_clk !== (k >= 3)) begin
                miscompares++;
                $display("FAIL presc_restart[%0d] got %b exp %b", k, timer_clk, k >= 3);
            end
            tick();
        end
    endtask

    task automatic test_oneshot();
        drive(1'b1, 2'd0, 2'd2, 8'h03);
        tick();
        drive(1'b0, 2'd0, 2'd0, 8'h00);
        repeat (2) tick();
        vectors++;
        if (timer_enabled[0] !== 1'b1 || done[0] !== 1'b0) begin
            miscompares++;
            $display("FAIL oneshot_armed got en0=%b done0=%b exp 1 0", timer_enabled[0], done[0]);
        end
        timer_out_in[0] = 1'b1;
        tick();
        vectors++;
        if (timer_enabled[0] !== 1'b1) begin
            miscompares++;
            $display("FAIL oneshot_rise got en0=%b exp 1", timer_enabled[0]);
        end
        timer_out_in[0] = 1'b0;
        tick();
        vectors++;
        if (timer_enabled[0] !== 1'b0 || done[0] !== 1'b1) begin
            miscompares++;
            $display("FAIL oneshot_fall got en0=%b done0=%b exp 0 1", timer_enabled[0], done[0]);
        end
        tick();
        vectors++;
        if (done[0] !== 1'b1 || timer_enabled[1] !== 1'b1) begin
            miscompares++;
            $display("FAIL oneshot_sticky got done0=%b en1=%b exp 1 1", done[0], timer_enabled[1]);
        end
        drive(1'b1, 2'd0, 2'd2, 8'h01);
        tick();
        drive(1'b0, 2'd0, 2'd0, 8'h00);
        vectors++;
        if (done[0] !== 1'b0) begin
            miscompares++;
            $display("FAIL oneshot_clear got done0=%b exp 0", done[0]);
        end
        repeat (2) tick();
        timer_out_in[0] = 1'b1;
        tick();
        timer_out_in[0] = 1'b0;
        repeat (2) tick();
        vectors++;
        if (timer_enabled !== 4'b0011 || done !== 4'b0000) begin
            miscompares++;
            $display("FAIL oneshot_off got en=%b done=%b exp 0011 0000", timer_enabled, done);
        end
    endtask

    task automatic test_collision();
        drive(1'b1, 2'd2, 2'd2, 8'h03);
        tick();
        drive(1'b0, 2'd0, 2'd0, 8'h00);
        repeat (2) tick();
        timer_out_in[2] = 1'b1;
        tick();
        vectors++;
        if (timer_enabled[2] !== 1'b1) begin
            miscompares++;
            $display("FAIL collide_armed got en2=%b exp 1", timer_enabled[2]);
        end
        timer_out_in[2] = 1'b0;
        drive(1'b1, 2'd2, 2'd2, 8'h01);
        tick();
        drive(1'b0, 2'd0, 2'd0, 8'h00);
        vectors++;
        if (done[2] !== 1'b0 || timer_enabled[2] !== 1'b0 || cfg_ready !== 1'b0) begin
            miscompares++;
            $display("FAIL collide_edge got done2=%b en2=%b ready=%b exp 0 0 0", done[2], timer_enabled[2], cfg_ready);
        end
        repeat (2) tick();
        vectors++;
        if (done[2] !== 1'b0 || timer_enabled[2] !== 1'b1) begin
            miscompares++;
            $display("FAIL collide_after got done2=%b en2=%b exp 0 1", done[2], timer_enabled[2]);
        end
    endtask

    task automatic test_back_to_back();
        drive(1'b1, 2'd3, 2'd2, 8'h01);
        tick();
        drive(1'b1, 2'd3, 2'd0, 8'hAA);
        tick();
        vectors++;
        if (cfg_ready !== 1'b0) begin
            miscompares++;
            $display("FAIL b2b_busy got ready=%b exp 0", cfg_ready);
        end
        tick();
        drive(1'b0, 2'd0, 2'd0, 8'h00);
        vectors++;
        if (cfg_ready !== 1'b1 || timer_enabled[3] !== 1'b1) begin
            miscompares++;
            $display("FAIL b2b_release got ready=%b en3=%b exp 1 1", cfg_ready, timer_enabled[3]);
        end
        drive(1'b1, 2'd3, 2'd2, 8'h01);
        tick();
        drive(1'b0, 2'd0, 2'd0, 8'h00);
        repeat (2) tick();
        vectors++;
        if (period_a[31:24] !== 8'h00 || timer_enabled !== 4'b1111) begin
            miscompares++;
            $display("FAIL b2b_no_write got pa3=%h en=%b exp 00 1111", period_a[31:24], timer_enabled);
        end
    endtask

    task automatic test_out_of_range();
        drive2(1'b1, 2'd3, 2'd0, 8'h11);
        tick();
        drive2(1'b1, 2'd3, 2'd2, 8'h01);
        tick();
        drive2(1'b0, 2'd0, 2'd0, 8'h00);
        vectors++;
        if (cfg_ready2 !== 1'b1 || period_a2 !== 16'h0000 || timer_enabled2 !== 2'b00) begin
            miscompares++;
            $display("FAIL oor_dropped got ready=%b pa=%h en=%b exp 1 0000 00", cfg_ready2, period_a2, timer_enabled2);
        end
        drive2(1'b1, 2'd1, 2'd1, 8'h22);
        tick();
        drive2(1'b1, 2'd1, 2'd2, 8'h01);
        tick();
        drive2(1'b0, 2'd0, 2'd0, 8'h00);
        repeat (2) tick();
        vectors++;
        if (period_a2 !== 16'h0000 || period_b2 !== 16'h2200 || timer_enabled2 !== 2'b10) begin
            miscompares++;
            $display("FAIL oor_no_alias got pa=%h pb=%h en=%b exp 0000 2200 10", period_a2, period_b2, timer_enabled2);
        end
    endtask

    initial begin
        @(negedge clk);
        test_reset();
        test_commit();
        test_prescaler();
        test_oneshot();
        test_collision();
        test_back_to_back();
        test_out_of_range();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
